// File: rtl/button_encoder_pkg.sv
// Shared definitions for the reaction-game button path: button/code widths,
// FSM state encodings and small helpers for decoding a sampled button vector.
package button_encoder_pkg;

  localparam int NUM_BTN = 4;
  localparam int CODE_W  = 2;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_REPORT   = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  // True when exactly one button is set (non-zero and a power of two).
  function automatic logic is_single(input logic [NUM_BTN-1:0] b);
    return (b != '0) && ((b & (b - NUM_BTN'(1))) == '0);
  endfunction

  function automatic logic [CODE_W-1:0] btn_index(input logic [NUM_BTN-1:0] b);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (b[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/button_encoder_sync_2ff.sv
// Parameterised-width two-flop synchronizer for asynchronous board inputs;
// also reused for the start/stop switches.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_encoder.sv
// Debounces the four player buttons and reports a single press as a 2-bit
// code with a one-cycle valid strobe; multi-button presses raise multi instead.
import button_encoder_pkg::*;

module button_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [CODE_W-1:0]  code,
  output logic               valid,
  output logic               multi,
  output logic               busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sbtn;
  logic [NUM_BTN-1:0] sample;
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               quiet;

  sync_2ff #(.W(NUM_BTN)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn),
    .q   (sbtn)
  );

  // In HOLD, the first released cycle only arms 'quiet' so that release is
  // qualified exactly like a press: one latch cycle plus DEBOUNCE_CYCLES-1 counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      sample <= '0;
      quiet  <= 1'b0;
      code   <= '0;
      valid  <= 1'b0;
      multi  <= 1'b0;
    end else begin
      valid <= 1'b0;
      multi <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (sbtn != '0) begin
            sample <= sbtn;
            cnt    <= '0;
            state  <= ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (sbtn == '0) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (sbtn != sample) begin
            sample <= sbtn;
            cnt    <= '0;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_REPORT;
            if (is_single(sample)) begin
              code  <= btn_index(sample);
              valid <= 1'b1;
            end else begin
              multi <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_REPORT: begin
          cnt   <= '0;
          quiet <= 1'b0;
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (sbtn != '0) begin
            cnt   <= '0;
            quiet <= 1'b0;
          end else if (!quiet) begin
            quiet <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_button_encoder.sv
// Scoreboard bench for button_encoder: expected pulses are queued when a press
// is driven and matched (kind, code, edge) whenever valid or multi fires.
module tb_button_encoder;

  localparam int DC  = 4;
  localparam int LAT = DC + 3;

  typedef struct {
    bit         isMulti;
    logic [1:0] code;
    int         cycle;
  } pulse_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [1:0] code;
  logic       valid;
  logic       multi;
  logic       busy;

  int     cyc    = 0;
  int     errors = 0;
  int     checks = 0;
  pulse_t sb[$];
  pulse_t p;

  button_encoder #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .code  (code),
    .valid (valid),
    .multi (multi),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Drive the buttons; optionally queue the pulse this press must produce.
  task automatic applyStimulus(input logic [3:0] b, input bit expectPulse,
                               input bit isMulti, input logic [1:0] c);
    pulse_t e;
    btn = b;
    if (expectPulse) begin
      e.isMulti = isMulti;
      e.code    = c;
      e.cycle   = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0 && (valid || multi)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pulse", 32'({valid, multi}), 32'd0);
      end else begin
        p = sb.pop_front();
        checkOutput("pulse_kind", 32'({valid, multi}), p.isMulti ? 32'b01 : 32'b10);
        checkOutput("pulse_code", 32'(code), 32'(p.code));
        checkOutput("pulse_cycle", 32'(cyc), 32'(p.cycle));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    btn = 4'b0000;
    waitCycles(3);
    checkOutput("reset_code", 32'(code), 32'd0);
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_multi", 32'(multi), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    waitCycles(2);

    // Single press of button 2, then release timing.
    applyStimulus(4'b0100, 1'b1, 1'b0, 2'b10);
    waitCycles(2);
    checkOutput("busy_before_debounce", 32'(busy), 32'd0);
    waitCycles(1);
    checkOutput("busy_enter_debounce", 32'(busy), 32'd1);
    waitCycles(7);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'b00);
    waitCycles(6);
    checkOutput("busy_release_tail", 32'(busy), 32'd1);
    waitCycles(1);
    checkOutput("busy_release_idle", 32'(busy), 32'd0);
    waitCycles(3);

    // Bouncing button 0: never stable long enough.
    for (int i = 0; i < 10; i++) begin
      applyStimulus((i % 2 == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0, 2'b00);
      waitCycles(2);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'b00);
    waitCycles(6);
    checkOutput("bounce_busy", 32'(busy), 32'd0);
    checkOutput("bounce_code", 32'(code), 32'd2);

    // Simultaneous two-button press gives multi, code unchanged.
    applyStimulus(4'b1010, 1'b1, 1'b1, 2'b10);
    waitCycles(12);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'b00);
    waitCycles(10);
    checkOutput("multi_code_kept", 32'(code), 32'd2);

    // Long press of button 3 with button 0 pulsed during HOLD.
    applyStimulus(4'b1000, 1'b1, 1'b0, 2'b11);
    waitCycles(15);
    applyStimulus(4'b1001, 1'b0, 1'b0, 2'b00);
    waitCycles(2);
    applyStimulus(4'b1000, 1'b0, 1'b0, 2'b00);
    waitCycles(33);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'b00);
    waitCycles(6);
    checkOutput("long_release_tail", 32'(busy), 32'd1);
    waitCycles(1);
    checkOutput("long_release_idle", 32'(busy), 32'd0);
    waitCycles(3);

    // Second button added during DEBOUNCE restarts with the combined sample.
    applyStimulus(4'b0001, 1'b0, 1'b0, 2'b00);
    waitCycles(2);
    applyStimulus(4'b0011, 1'b1, 1'b1, 2'b11);
    waitCycles(12);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'b00);
    waitCycles(10);

    // Reset in the middle of DEBOUNCE, button still held afterwards.
    applyStimulus(4'b0010, 1'b0, 1'b0, 2'b00);
    waitCycles(4);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midreset_code", 32'(code), 32'd0);
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_pulses", 32'({valid, multi}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'b01);
    waitCycles(12);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'b00);
    waitCycles(10);
    checkOutput("final_busy", 32'(busy), 32'd0);

    checkOutput("pending_pulses", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
